uart_alu_frame_if: RTL and testbench
====================================

// Module: uart_alu_frame_if
// PURPOSE
//  Framed bridge between the UART RX/TX byte engines and a wide combinational ALU.
//  Collects an opcode byte plus multi-byte A and B operands (LSB byte first), presents them to the ALU,
//  captures the result and streams it back through UART TX, LSB byte first.
//  Successor to the fixed 8-bit interface: parametrised operand width, inactivity timeout, framing errors.
// PARAMETERS
//  NB_DATA        8     UART byte width
//  NB_OPERAND     16    ALU operand/result width; integer multiple of NB_DATA (NBYTES = NB_OPERAND/NB_DATA, >=1)
//  NB_ALU_OP      6     ALU opcode width; taken from i_rx_data[NB_ALU_OP-1:0] (NB_ALU_OP <= NB_DATA)
//  TIMEOUT_CYCLES 50000 max i_clk cycles between RX bytes inside a frame; 0 disables timeout
// PORTS
//  i_clk        in   1           system clock, rising edge
//  i_rst_n      in   1           asynchronous active-low reset
//  i_rx_data    in   NB_DATA     received byte, valid when i_rx_done=1
//  i_rx_done    in   1           one-cycle pulse: new RX byte
//  i_tx_done    in   1           one-cycle pulse: TX engine finished current byte
//  i_alu_res    in   NB_OPERAND  ALU result (combinational from o_alu_*)
//  o_tx_start   out  1           one-cycle pulse: start sending o_tx_data
//  o_tx_data    out  NB_DATA     byte to transmit, stable from o_tx_start until i_tx_done
//  o_alu_op     out  NB_ALU_OP   registered opcode
//  o_alu_a      out  NB_OPERAND  registered operand A
//  o_alu_b      out  NB_OPERAND  registered operand B
//  o_busy       out  1           1 whenever state != IDLE
//  o_frame_err  out  1           one-cycle pulse: frame aborted (timeout or checksum)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state IDLE, all outputs, byte counter, timeout counter, result reg = 0.
//  - States: IDLE -> RX_A -> RX_B -> [RX_CHK] -> EXEC -> TX_LOAD <-> TX_WAIT -> IDLE.
//  - IDLE: on i_rx_done, o_alu_op <= i_rx_data[NB_ALU_OP-1:0], cnt<=0 -> RX_A.
//  - RX_A/RX_B: each i_rx_done writes byte into operand[cnt*NB_DATA +: NB_DATA], cnt++;
//    at cnt==NBYTES-1 clear cnt, advance. o_alu_a/b updated progressively; only sampled in EXEC.
//  - EXEC: exactly one cycle; result_reg <= i_alu_res -> TX_LOAD. Last-byte rx_done at edge N => EXEC in N+1,
//    o_tx_start high in cycle N+2.
//  - TX_LOAD: o_tx_start=1 one cycle, o_tx_data = result_reg[NB_DATA-1:0] -> TX_WAIT.
//  - TX_WAIT: on i_tx_done shift result_reg right NB_DATA, cnt++; after NBYTES bytes -> IDLE, else TX_LOAD.
//  - Timeout: counter clears on every i_rx_done, counts in RX_* states; reaching TIMEOUT_CYCLES ->
//    o_frame_err pulse, partial frame discarded, -> IDLE. i_rx_done in the same cycle wins (no abort).
//  - i_rx_done in EXEC/TX_LOAD/TX_WAIT: byte dropped, no state effect. i_tx_done outside TX_WAIT ignored.
//  - o_alu_* hold last values after frame end until overwritten by next frame.
// CONFIGURATION
//  UART_ALU_FRAME_CHECKSUM_EN defined: after B, state RX_CHK receives one byte; XOR of opcode byte, all A,
//   B bytes and checksum byte must be 0. Pass -> EXEC. Fail -> o_frame_err pulse, no EXEC, transmit single
//   NACK byte {NB_DATA{1'b1}} (TX_LOAD/TX_WAIT once) -> IDLE. Timeout applies in RX_CHK.
//  Not defined: no RX_CHK state, no NACK; o_frame_err only from timeout.
// TESTING (NB_OPERAND=16, TIMEOUT_CYCLES=100, ALU model = A+B)
//  1. RX 20,34,12,01,01 -> o_alu_op=0x20, A=0x1234, B=0x0101; TX 0x35 then 0x13; o_busy low after 2nd i_tx_done.
//  2. RX 20,34 then 100 idle cycles -> o_frame_err one pulse, IDLE; next full frame of test 1 gives 0x35,0x13.
//  3. Extra RX byte 0xAA during TX_WAIT -> dropped; TX still 0x35,0x13; next frame decodes from following byte.
//  4. i_rst_n low during TX_WAIT of byte 0 -> all outputs 0, IDLE; no further o_tx_start until new frame.
//  5. rx_done coincident with timeout expiry (99 idle then byte) -> no error, frame continues.
//  6. CHECKSUM_EN: RX 20,34,12,01,01,06 -> TX 0x35,0x13; checksum 0x07 -> o_frame_err pulse, TX 0xFF only.

Source files
------------

// File: rtl/uart_alu_frame_if.sv
// Framed bridge: opcode + multi-byte A/B from UART RX into a combinational ALU, result back out over UART TX LSB first.
// Latency: last operand byte at edge N -> EXEC in N+1 -> o_tx_start in N+2; one TX byte per i_tx_done handshake.
// Backpressure: none on RX (bytes outside RX states are dropped); TX waits on i_tx_done. Option: UART_ALU_FRAME_CHECKSUM_EN.
module uart_alu_frame_if #(
    parameter int NB_DATA        = 8,
    parameter int NB_OPERAND     = 16,
    parameter int NB_ALU_OP      = 6,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NB_DATA-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    input  logic [NB_OPERAND-1:0] i_alu_res,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic [NB_ALU_OP-1:0]  o_alu_op,
    output logic [NB_OPERAND-1:0] o_alu_a,
    output logic [NB_OPERAND-1:0] o_alu_b,
    output logic                  o_busy,
    output logic                  o_frame_err
);

    localparam int NBYTES = NB_OPERAND / NB_DATA;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_A    = 3'd1,
        RX_B    = 3'd2,
        RX_CHK  = 3'd3,
        EXEC    = 3'd4,
        TX_LOAD = 3'd5,
        TX_WAIT = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [NB_ALU_OP-1:0]    op_q, op_d;
    logic [NB_OPERAND-1:0]   a_q, a_d;
    logic [NB_OPERAND-1:0]   b_q, b_d;
    logic [NB_OPERAND-1:0]   res_q, res_d;
    logic                    err_q, err_d;
    logic                    rx_state;
    logic                    tmo_hit;
`ifdef UART_ALU_FRAME_CHECKSUM_EN
    logic [NB_DATA-1:0]      chk_q, chk_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef UART_ALU_FRAME_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef UART_ALU_FRAME_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        err_d    = 1'b0;
        tmo_d    = '0;
`ifdef UART_ALU_FRAME_CHECKSUM_EN
        chk_d    = chk_q;
`endif
        rx_state = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_CHK);
        // A byte arriving on the expiry cycle keeps the frame alive.
        tmo_hit  = TMO_EN && rx_state && !i_rx_done && (tmo_q == TMO_LAST);
        if (TMO_EN && rx_state && !i_rx_done) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[NB_ALU_OP-1:0];
                    cnt_d   = '0;
                    state_d = RX_A;
`ifdef UART_ALU_FRAME_CHECKSUM_EN
                    chk_d   = i_rx_data;
`endif
                end
            end
            RX_A: begin
                if (i_rx_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) a_d[k*NB_DATA +: NB_DATA] = i_rx_data;
                    end
`ifdef UART_ALU_FRAME_CHECKSUM_EN
                    chk_d = chk_q ^ i_rx_data;
`endif
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = RX_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RX_B: begin
                if (i_rx_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) b_d[k*NB_DATA +: NB_DATA] = i_rx_data;
                    end
`ifdef UART_ALU_FRAME_CHECKSUM_EN
                    chk_d = chk_q ^ i_rx_data;
`endif
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
`ifdef UART_ALU_FRAME_CHECKSUM_EN
                        state_d = RX_CHK;
`else
                        state_d = EXEC;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_ALU_FRAME_CHECKSUM_EN
            RX_CHK: begin
                if (i_rx_done) begin
                    if ((chk_q ^ i_rx_data) == '0) begin
                        state_d = EXEC;
                    end else begin
                        // Preloading the counter to the last slot makes the NACK a single-byte reply.
                        err_d                 = 1'b1;
                        res_d                 = '0;
                        res_d[NB_DATA-1:0]    = '1;
                        cnt_d                 = CNT_LAST;
                        state_d               = TX_LOAD;
                    end
                end
            end
`endif
            EXEC: begin
                res_d   = i_alu_res;
                cnt_d   = '0;
                state_d = TX_LOAD;
            end
            TX_LOAD: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    res_d = res_q >> NB_DATA;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = TX_LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (tmo_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
            err_d   = 1'b1;
        end
    end

    always_comb begin
        o_busy      = (state_q != IDLE);
        o_tx_start  = (state_q == TX_LOAD);
        o_tx_data   = res_q[NB_DATA-1:0];
        o_alu_op    = op_q;
        o_alu_a     = a_q;
        o_alu_b     = b_q;
        o_frame_err = err_q;
    end

endmodule

// File: tb/tb_uart_alu_frame_if.sv
// Directed bench for uart_alu_frame_if with a 16-bit adder as the ALU and a hand-driven TX engine.
module tb_uart_alu_frame_if;

    localparam int NB_DATA    = 8;
    localparam int NB_OPERAND = 16;
    localparam int NB_ALU_OP  = 6;
    localparam int TMO        = 100;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NB_DATA-1:0]    rx_data = '0;
    logic                  rx_done = 1'b0;
    logic                  tx_done = 1'b0;
    logic [NB_OPERAND-1:0] alu_res;
    logic                  tx_start;
    logic [NB_DATA-1:0]    tx_data;
    logic [NB_ALU_OP-1:0]  alu_op;
    logic [NB_OPERAND-1:0] alu_a;
    logic [NB_OPERAND-1:0] alu_b;
    logic                  busy;
    logic                  frame_err;

    int n_chk = 0;
    int n_err = 0;
    int err_pulses = 0;
    int start_pulses = 0;
    int e0;
    int s0;

    uart_alu_frame_if #(
        .NB_DATA(NB_DATA), .NB_OPERAND(NB_OPERAND), .NB_ALU_OP(NB_ALU_OP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_alu_res(alu_res), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_busy(busy), .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign alu_res = alu_a + alu_b;

    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (tx_start)  start_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        send_rx(op);
        send_rx(a[7:0]);
        send_rx(a[15:8]);
        send_rx(b[7:0]);
        send_rx(b[15:8]);
`ifdef UART_ALU_FRAME_CHECKSUM_EN
        send_rx(op ^ a[7:0] ^ a[15:8] ^ b[7:0] ^ b[15:8]);
`endif
    endtask

    // Acts as the TX engine: waits for a start pulse, checks the byte, optionally injects an RX byte, then acks.
    task automatic tx_expect(input string tag, input logic [7:0] exp, input bit inj, input logic [7:0] inj_b);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_start) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_start"}, {31'd0, found}, 32'd1);
        if (found) begin
            check({tag, "_dat"}, {24'd0, tx_data}, {24'd0, exp});
            tick();
            check({tag, "_pulse"}, {31'd0, tx_start}, 32'd0);
            if (inj) send_rx(inj_b);
            else     tick();
            check({tag, "_hold"}, {24'd0, tx_data}, {24'd0, exp});
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_start", {31'd0, tx_start},  32'd0);
        check("rst_err",   {31'd0, frame_err}, 32'd0);
        check("rst_op",    {26'd0, alu_op},    32'd0);
        check("rst_a",     {16'd0, alu_a},     32'd0);
        check("rst_b",     {16'd0, alu_b},     32'd0);
        check("rst_txd",   {24'd0, tx_data},   32'd0);

        // Basic frame and the last-byte -> tx_start latency.
        send_frame(8'h20, 16'h1234, 16'h0101);
        check("t1_busy",  {31'd0, busy},     32'd1);
        check("t1_op",    {26'd0, alu_op},   32'h20);
        check("t1_a",     {16'd0, alu_a},    32'h1234);
        check("t1_b",     {16'd0, alu_b},    32'h0101);
        check("t1_exec",  {31'd0, tx_start}, 32'd0);
        tick();
        check("t1_lat",   {31'd0, tx_start}, 32'd1);
        s0 = start_pulses;
        tx_expect("t1_b0", 8'h35, 1'b0, 8'h00);
        tx_expect("t1_b1", 8'h13, 1'b0, 8'h00);
        check("t1_done",  {31'd0, busy},     32'd0);
        check("t1_nstart", start_pulses - s0, 32'd2);

        // Result wraps at operand width.
        send_frame(8'h01, 16'hFFFF, 16'h0002);
        tx_expect("t1b_b0", 8'h01, 1'b0, 8'h00);
        tx_expect("t1b_b1", 8'h00, 1'b0, 8'h00);
        check("t1b_done", {31'd0, busy}, 32'd0);

        // Timeout after 100 idle cycles inside a frame.
        e0 = err_pulses;
        send_rx(8'h20);
        send_rx(8'h34);
        idle(99);
        check("t2_noerr99", err_pulses - e0, 32'd0);
        check("t2_busy99",  {31'd0, busy},      32'd1);
        tick();
        check("t2_err",     {31'd0, frame_err}, 32'd1);
        check("t2_idle",    {31'd0, busy},      32'd0);
        tick();
        check("t2_pulse1",  err_pulses - e0,    32'd1);
        check("t2_errlow",  {31'd0, frame_err}, 32'd0);
        send_frame(8'h20, 16'h1234, 16'h0101);
        tx_expect("t2_b0", 8'h35, 1'b0, 8'h00);
        tx_expect("t2_b1", 8'h13, 1'b0, 8'h00);

        // Byte arriving exactly on the expiry cycle keeps the frame alive.
        e0 = err_pulses;
        send_rx(8'h05);
        idle(99);
        send_rx(8'hFF);
        idle(99);
        send_rx(8'h00);
        send_rx(8'h01);
        send_rx(8'h00);
`ifdef UART_ALU_FRAME_CHECKSUM_EN
        send_rx(8'hFB);
`endif
        check("t5_noerr", err_pulses - e0,   32'd0);
        check("t5_a",     {16'd0, alu_a},    32'h00FF);
        check("t5_b",     {16'd0, alu_b},    32'h0001);
        tx_expect("t5_b0", 8'h00, 1'b0, 8'h00);
        tx_expect("t5_b1", 8'h01, 1'b0, 8'h00);

        // RX byte during TX_WAIT is dropped.
        send_frame(8'h20, 16'h1234, 16'h0101);
        tx_expect("t3_b0", 8'h35, 1'b1, 8'hAA);
        tx_expect("t3_b1", 8'h13, 1'b0, 8'h00);
        check("t3_done", {31'd0, busy}, 32'd0);
        send_frame(8'h3F, 16'h0001, 16'h0002);
        check("t3_op",   {26'd0, alu_op}, 32'h3F);
        tx_expect("t3_n0", 8'h03, 1'b0, 8'h00);
        tx_expect("t3_n1", 8'h00, 1'b0, 8'h00);

        // Async reset in the middle of a transmission.
        send_frame(8'h20, 16'h1234, 16'h0101);
        tick();
        check("t4_start", {31'd0, tx_start}, 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_busy",  {31'd0, busy},      32'd0);
        check("t4_txs",   {31'd0, tx_start},  32'd0);
        check("t4_err",   {31'd0, frame_err}, 32'd0);
        check("t4_op",    {26'd0, alu_op},    32'd0);
        check("t4_a",     {16'd0, alu_a},     32'd0);
        check("t4_b",     {16'd0, alu_b},     32'd0);
        check("t4_txd",   {24'd0, tx_data},   32'd0);
        tick();
        rst_n = 1'b1;
        s0 = start_pulses;
        idle(30);
        check("t4_nostart", start_pulses - s0, 32'd0);
        check("t4_idle",    {31'd0, busy},     32'd0);

`ifdef UART_ALU_FRAME_CHECKSUM_EN
        // Explicit good checksum, then a bad one that yields a single NACK byte.
        send_rx(8'h20); send_rx(8'h34); send_rx(8'h12); send_rx(8'h01); send_rx(8'h01); send_rx(8'h06);
        tx_expect("t6_b0", 8'h35, 1'b0, 8'h00);
        tx_expect("t6_b1", 8'h13, 1'b0, 8'h00);
        e0 = err_pulses;
        s0 = start_pulses;
        send_rx(8'h20); send_rx(8'h34); send_rx(8'h12); send_rx(8'h01); send_rx(8'h01); send_rx(8'h07);
        check("t6_err", {31'd0, frame_err}, 32'd1);
        tx_expect("t6_nack", 8'hFF, 1'b0, 8'h00);
        check("t6_done", {31'd0, busy}, 32'd0);
        idle(20);
        check("t6_nstart", start_pulses - s0, 32'd1);
        check("t6_nerr",   err_pulses - e0,   32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
